// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin burst arbiter sharing one rom_sync read port
module rom_arbiter #(
    parameter int NREQ  = 2,
    parameter int ADDRW = 10,
    parameter int DATAW = 16,
    parameter int LENW  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ADDRW-1:0] req_addr,
    input  logic [NREQ*LENW-1:0]  req_len,
    output logic [NREQ-1:0]       resp_valid,
    output logic                  resp_last,
    output logic [DATAW-1:0]      resp_data,
    output logic [ADDRW-1:0]      rom_addr,
    input  logic [DATAW-1:0]      rom_data,
    output logic                  busy
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state, state_next;
    logic [PTRW-1:0]   rr_ptr;
    logic [PTRW-1:0]   owner;
    logic [ADDRW-1:0]  addr_q;
    logic [LENW-1:0]   remaining;

    logic              grant_found;
    logic [PTRW-1:0]   grant_idx;
    logic [PTRW:0]     cand;
    logic [ADDRW-1:0]  grant_addr;
    logic [LENW-1:0]   grant_len;

    // Search starts just after the last winner; one extra bit lets the sum wrap without a modulo.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTRW+1)'(k);
            if (cand >= (PTRW+1)'(NREQ))
                cand = cand - (PTRW+1)'(NREQ);
            if (!grant_found && req_valid[cand[PTRW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTRW-1:0];
            end
        end
    end

    assign grant_addr = req_addr[grant_idx*ADDRW +: ADDRW];
    assign grant_len  = req_len[grant_idx*LENW +: LENW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found && grant_len != '0) state_next = BURST;
            BURST:   if (remaining == LENW'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rom_addr  = addr_q;
        busy      = (state == BURST);
        if (state == IDLE && grant_found) begin
            req_ready = NREQ'(1) << grant_idx;
            rom_addr  = grant_addr;
        end
    end

    // Response flags trail the issued address by one cycle to line up with rom_sync latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= PTRW'(NREQ-1);
            owner      <= '0;
            addr_q     <= '0;
            remaining  <= '0;
            resp_valid <= '0;
            resp_last  <= 1'b0;
        end else begin
            resp_valid <= '0;
            resp_last  <= 1'b0;
            if (state == IDLE) begin
                if (grant_found) begin
                    addr_q     <= grant_addr + ADDRW'(1);
                    remaining  <= grant_len;
                    owner      <= grant_idx;
                    rr_ptr     <= grant_idx;
                    resp_valid <= NREQ'(1) << grant_idx;
                    resp_last  <= (grant_len == '0);
                end
            end else begin
                addr_q     <= addr_q + ADDRW'(1);
                remaining  <= remaining - LENW'(1);
                resp_valid <= NREQ'(1) << owner;
                resp_last  <= (remaining == LENW'(1));
            end
        end
    end

    assign resp_data = rom_data;

endmodule
